// File: rtl/aes_key_expand.sv
// AES key schedule: loads a 128/192/256-bit key, expands one 32-bit word per cycle, serves round keys by index.
// Optional macro AES_KEY_DECRYPT_ORDER_EN adds AES_rk_rd_rev to serve rounds in reverse (decryption) order.
module aes_key_expand #(
    parameter int KEY_BITS = 128
) (
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_key_en,
    input  logic [255:0] AES_key_in,
    input  logic         AES_rk_rd_en,
    input  logic [3:0]   AES_rk_rd_addr,
`ifdef AES_KEY_DECRYPT_ORDER_EN
    input  logic         AES_rk_rd_rev,
`endif
    output logic         AES_key_busy,
    output logic         AES_key_ready,
    output logic [127:0] AES_rk_out,
    output logic         AES_rk_out_valid,
    output logic         AES_rk_err
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    // FIPS-197 S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    state_t       r_state;
    state_t       w_state_nxt;
    logic [5:0]   r_i;
    logic [2:0]   r_mod;
    logic [7:0]   r_rcon;
    logic [31:0]  w_words [0:NW-1];
    logic [31:0]  w_prev;
    logic [31:0]  w_back;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_new;
    logic         w_start;
    logic         w_last;
    logic         w_load_key;
    logic         w_wr_exp;
    logic [3:0]   w_round;
    logic [5:0]   w_base;
    logic         w_rd_ok;
    logic         w_rd_bad;
    logic [127:0] w_rk;

    assign w_start    = AES_key_en && (r_state != EXPAND);
    assign w_last     = (r_i == 6'(NW - 1));
    assign w_load_key = !AES_rst && w_start;
    assign w_wr_exp   = !AES_rst && (r_state == EXPAND);

    assign w_prev = w_words[r_i - 6'd1];
    assign w_back = w_words[r_i - 6'(NK)];
    assign w_sub  = sub_word((r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev);
    assign w_new  = w_back ^ w_t;

    // Temporary word t: RotWord+SubWord+Rcon at the start of each key-length group, extra SubWord mid-group for 256-bit keys.
    always_comb begin
        w_t = w_prev;
        if (r_mod == 3'd0) begin
            w_t = w_sub ^ {r_rcon, 24'h000000};
        end else if ((NK == 8) && (r_mod == 3'd4)) begin
            w_t = w_sub;
        end else begin
            w_t = w_prev;
        end
    end

    // Word storage is deliberately not reset; readiness alone guards its contents.
    for (genvar g = 0; g < NW; g++) begin : g_word
        logic [31:0] r_word;
        if (g < NK) begin : g_key
            always_ff @(posedge AES_clk) begin
                if (w_load_key) begin
                    r_word <= AES_key_in[255 - 32*g -: 32];
                end else begin
                    r_word <= r_word;
                end
            end
        end else begin : g_exp
            always_ff @(posedge AES_clk) begin
                if (w_wr_exp && (r_i == 6'(g))) begin
                    r_word <= w_new;
                end else begin
                    r_word <= r_word;
                end
            end
        end
        assign w_words[g] = r_word;
    end

    if (KEY_BITS < 256) begin : g_key_pad
        logic w_unused_key;
        assign w_unused_key = ^AES_key_in[255 - KEY_BITS:0];
    end

    // State register.
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a start request during EXPAND is ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = AES_key_en ? EXPAND : IDLE;
            EXPAND:  w_state_nxt = w_last ? DONE : EXPAND;
            DONE:    w_state_nxt = AES_key_en ? EXPAND : DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Word index, position within the key-length group, and current Rcon byte.
    always_ff @(posedge AES_clk) begin
        if (AES_rst || w_start) begin
            r_i    <= 6'(NK);
            r_mod  <= 3'd0;
            r_rcon <= 8'h01;
        end else if (r_state == EXPAND) begin
            r_i    <= w_last ? r_i : r_i + 6'd1;
            r_mod  <= (r_mod == 3'(NK - 1)) ? 3'd0 : r_mod + 3'd1;
            r_rcon <= (r_mod == 3'd0) ? xtime(r_rcon) : r_rcon;
        end else begin
            r_i    <= r_i;
            r_mod  <= r_mod;
            r_rcon <= r_rcon;
        end
    end

`ifdef AES_KEY_DECRYPT_ORDER_EN
    assign w_round = AES_rk_rd_rev ? (4'(NR) - AES_rk_rd_addr) : AES_rk_rd_addr;
`else
    assign w_round = AES_rk_rd_addr;
`endif

    // Range check uses the raw address, so reversal never masks an illegal request.
    assign w_rd_ok  = AES_rk_rd_en && (r_state == DONE) && (AES_rk_rd_addr <= 4'(NR));
    assign w_rd_bad = AES_rk_rd_en && !w_rd_ok;
    assign w_base   = {w_round, 2'b00};

    // Round-key mux, only indexed for legal reads.
    always_comb begin
        w_rk = 128'h0;
        if (w_rd_ok) begin
            w_rk = {w_words[w_base], w_words[w_base + 6'd1],
                    w_words[w_base + 6'd2], w_words[w_base + 6'd3]};
        end else begin
            w_rk = 128'h0;
        end
    end

    // Registered outputs; status follows the state being entered.
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            AES_key_busy     <= 1'b0;
            AES_key_ready    <= 1'b0;
            AES_rk_out       <= 128'h0;
            AES_rk_out_valid <= 1'b0;
            AES_rk_err       <= 1'b0;
        end else begin
            AES_key_busy     <= (w_state_nxt == EXPAND);
            AES_key_ready    <= (w_state_nxt == DONE);
            AES_rk_out       <= w_rd_ok ? w_rk : AES_rk_out;
            AES_rk_out_valid <= w_rd_ok;
            AES_rk_err       <= w_rd_bad;
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench: one instance per key length against a GF(2^8)-derived key-schedule model.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst     [3];
    logic         key_en  [3];
    logic [255:0] key_in  [3];
    logic         rd_en   [3];
    logic [3:0]   addr    [3];
`ifdef AES_KEY_DECRYPT_ORDER_EN
    logic         rev     [3];
`endif
    logic         busy    [3];
    logic         ready   [3];
    logic [127:0] rk_out  [3];
    logic         valid   [3];
    logic         err     [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sb    [256];
    logic [31:0]  ref_w [60];
    logic [255:0] kv    [3];
    logic [127:0] kr    [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_key_expand #(.KEY_BITS(128 + 64*g)) u_dut (
            .AES_clk          (clk),
            .AES_rst          (rst[g]),
            .AES_key_en       (key_en[g]),
            .AES_key_in       (key_in[g]),
            .AES_rk_rd_en     (rd_en[g]),
            .AES_rk_rd_addr   (addr[g]),
`ifdef AES_KEY_DECRYPT_ORDER_EN
            .AES_rk_rd_rev    (rev[g]),
`endif
            .AES_key_busy     (busy[g]),
            .AES_key_ready    (ready[g]),
            .AES_rk_out       (rk_out[g]),
            .AES_rk_out_valid (valid[g]),
            .AES_rk_err       (err[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in, b = b_in, p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    function automatic logic [127:0] ref_rk(input int r);
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int m = 0; m < 254; m++) inv = gmul(inv, 8'(x));
            b = inv;
            sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    task automatic model(input logic [255:0] key, input int nk);
        int nw = 4 * (nk + 7);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < nk; i++) ref_w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = ref_w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int m = 1; m < i / nk; m++) rc = gmul(rc, 8'h02);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            ref_w[i] = ref_w[i-nk] ^ t;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input int d, input string tag);
        chk({tag, "_busy"},  128'(busy[d]),  128'd0);
        chk({tag, "_ready"}, 128'(ready[d]), 128'd0);
        chk({tag, "_valid"}, 128'(valid[d]), 128'd0);
        chk({tag, "_err"},   128'(err[d]),   128'd0);
        chk({tag, "_rk"},    rk_out[d],      128'd0);
    endtask

    // Starts an expansion (optionally with a same-cycle read of round rd_a), probes a read and a
    // stray start mid-expansion, then checks the start-to-ready latency.
    task automatic expand_run(input int d, input logic [255:0] k, input int lat,
                              input bit with_rd, input int rd_a, input logic [127:0] rd_exp);
        int cnt;
        logic [127:0] hold;
        key_in[d] = k;
        key_en[d] = 1'b1;
        rd_en[d]  = with_rd;
        addr[d]   = 4'(rd_a);
        tick();
        key_en[d] = 1'b0;
        rd_en[d]  = 1'b0;
        key_in[d] = ~k;
        chk("start_busy", 128'(busy[d]), 128'd1);
        chk("start_ready_drop", 128'(ready[d]), 128'd0);
        if (with_rd) begin
            chk("restart_rd_valid", 128'(valid[d]), 128'd1);
            chk("restart_rd_old", rk_out[d], rd_exp);
        end
        cnt = 1;
        while (ready[d] !== 1'b1 && cnt < 200) begin
            hold = rk_out[d];
            if (cnt == 3) begin rd_en[d] = 1'b1; addr[d] = 4'd0; end
            if (cnt == 8) key_en[d] = 1'b1;
            tick();
            cnt++;
            if (cnt == 4) begin
                chk("exp_rd_err", 128'(err[d]), 128'd1);
                chk("exp_rd_valid", 128'(valid[d]), 128'd0);
                chk("exp_rd_hold", rk_out[d], hold);
            end
            rd_en[d]  = 1'b0;
            key_en[d] = 1'b0;
        end
        chk("latency", 128'(cnt), 128'(lat));
        chk("done_busy", 128'(busy[d]), 128'd0);
    endtask

    task automatic read_all(input int d, input int nr, input bit rnd, input bit rv);
        int a;
        for (int j = 0; j <= nr; j++) begin
            a = rnd ? int'($urandom_range(0, nr)) : j;
            rd_en[d] = 1'b1;
            addr[d]  = 4'(a);
`ifdef AES_KEY_DECRYPT_ORDER_EN
            rev[d]   = rv;
`endif
            tick();
            chk("rd_valid", 128'(valid[d]), 128'd1);
            chk("rd_err", 128'(err[d]), 128'd0);
            chk("rd_rk", rk_out[d], ref_rk(rv ? nr - a : a));
        end
        rd_en[d] = 1'b0;
`ifdef AES_KEY_DECRYPT_ORDER_EN
        rev[d]   = 1'b0;
`endif
        tick();
        chk("rd_valid_drop", 128'(valid[d]), 128'd0);
    endtask

    task automatic err_read(input int d, input int a);
        logic [127:0] hold = rk_out[d];
        rd_en[d] = 1'b1;
        addr[d]  = 4'(a);
        tick();
        rd_en[d] = 1'b0;
        chk("bad_addr_err", 128'(err[d]), 128'd1);
        chk("bad_addr_valid", 128'(valid[d]), 128'd0);
        chk("bad_addr_hold", rk_out[d], hold);
        tick();
        chk("bad_addr_err_drop", 128'(err[d]), 128'd0);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int nk, nr, nw;
        logic [255:0] ka, kb;
        logic [127:0] old_rk;
        kv[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        kv[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        kv[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        kr[0] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        kr[1] = 128'he98ba06f448c773c8ecc720401002202;
        kr[2] = 128'hfe4890d1e6188d0b046df344706c631e;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; key_en[d] = 1'b0; key_in[d] = 256'h0; rd_en[d] = 1'b0; addr[d] = 4'd0;
`ifdef AES_KEY_DECRYPT_ORDER_EN
            rev[d] = 1'b0;
`endif
        end
        build_sbox();

        for (int d = 0; d < 3; d++) begin
            nk = 4 + 2*d;
            nr = nk + 6;
            nw = 4 * (nr + 1);

            // Reset, with a start request that reset must override.
            key_en[d] = 1'b1;
            tick();
            tick();
            key_en[d] = 1'b0;
            check_zero(d, "reset");
            rst[d] = 1'b0;
            tick();
            chk("idle_ready", 128'(ready[d]), 128'd0);

            // Published vector, full in-order readback plus error reads.
            model(kv[d], nk);
            expand_run(d, kv[d], nw - nk + 1, 1'b0, 0, 128'h0);
            read_all(d, nr, 1'b0, 1'b0);
            rd_en[d] = 1'b1; addr[d] = 4'(nr);
            tick();
            rd_en[d] = 1'b0;
            chk("vector_last_round", rk_out[d], kr[d]);
            if (d == 2) begin
                rd_en[d] = 1'b1; addr[d] = 4'd0;
                tick();
                rd_en[d] = 1'b0;
                chk("vector_round0", rk_out[d], kv[2][255:128]);
            end
            err_read(d, nr + 1);
            err_read(d, 15);

            // Random keys, random back-to-back reads.
            for (int n = 0; n < 2; n++) begin
                ka = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
                model(ka, nk);
                expand_run(d, ka, nw - nk + 1, 1'b0, 0, 128'h0);
                read_all(d, nr, 1'b1, 1'b0);
            end

            // Restart with a same-cycle read: old schedule served, new one built.
            old_rk = ref_rk(nr);
            kb = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            model(kb, nk);
            expand_run(d, kb, nw - nk + 1, 1'b1, nr, old_rk);
            read_all(d, nr, 1'b1, 1'b0);

`ifdef AES_KEY_DECRYPT_ORDER_EN
            read_all(d, nr, 1'b0, 1'b1);
            rd_en[d] = 1'b1; addr[d] = 4'd0; rev[d] = 1'b1;
            model(kb, nk);
            tick();
            rd_en[d] = 1'b0; rev[d] = 1'b0;
            chk("rev_addr0", rk_out[d], ref_rk(nr));
            err_read(d, nr + 1);
`endif

            // Reset 20 cycles into an expansion aborts it.
            key_in[d] = ka;
            key_en[d] = 1'b1;
            tick();
            key_en[d] = 1'b0;
            for (int c = 0; c < 19; c++) tick();
            rst[d] = 1'b1;
            tick();
            rst[d] = 1'b0;
            check_zero(d, "mid_reset");
            for (int c = 0; c < 60; c++) tick();
            chk("abort_ready", 128'(ready[d]), 128'd0);
            chk("abort_busy", 128'(busy[d]), 128'd0);
            model(kv[d], nk);
            expand_run(d, kv[d], nw - nk + 1, 1'b0, 0, 128'h0);
            rd_en[d] = 1'b1; addr[d] = 4'(nr);
`ifdef AES_KEY_DECRYPT_ORDER_EN
            rev[d] = 1'b0;
`endif
            tick();
            rd_en[d] = 1'b0;
            chk("restart_last_round", rk_out[d], kr[d]);
            chk("restart_valid", 128'(valid[d]), 128'd1);
            rst[d] = 1'b1;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 The block SHALL have parameter KEY_BITS, default 128, AES key length; legal values 128, 192, 256.
REQ-002 The block SHALL have derived localparams NK=KEY_BITS/32, NR=NK+6, NW=4*(NR+1), giving 44, 52 or 60 words.
REQ-003 The block SHALL have port AES_clk  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port AES_rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port AES_key_en  input  1  start pulse; latches the key and begins expansion.
REQ-006 The block SHALL have port AES_key_in  input  256  cipher key, left-aligned; bits [255:256-KEY_BITS] used, [255:224] = w[0].
REQ-007 The block SHALL have port AES_rk_rd_en  input  1  round-key read request.
REQ-008 The block SHALL have port AES_rk_rd_addr  input  4  requested round index 0..NR.
REQ-009 The block SHALL have port AES_key_busy  output  1  high while expansion is in progress.
REQ-010 The block SHALL have port AES_key_ready  output  1  high while the schedule is complete and readable.
REQ-011 The block SHALL have port AES_rk_out  output  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}.
REQ-012 The block SHALL have port AES_rk_out_valid  output  1  one-cycle qualifier for AES_rk_out.
REQ-013 The block SHALL have port AES_rk_err  output  1  one-cycle pulse on an illegal read.

Function
REQ-014 The block SHALL implement FSM states IDLE, EXPAND, DONE.
REQ-015 In IDLE or DONE, AES_key_en=1 SHALL write w[0..NK-1] from AES_key_in, set word counter i=NK, and go to EXPAND; AES_key_ready SHALL drop in the same edge.
REQ-016 In EXPAND, the block SHALL compute exactly one word per cycle: w[i]=w[i-NK]^t, where t=w[i-1].
REQ-017 The expansion SHALL apply these substitutions to t: if i%NK==0, t=SubWord(RotWord(w[i-1]))^Rcon[i/NK]; else if NK==8 and i%NK==4, t=SubWord(w[i-1]).
REQ-018 Rcon SHALL be {01,02,04,08,10,20,40,80,1b,36} in the MSB byte with zeros below; SubWord SHALL be four parallel FIPS-197 S-box lookups in the block.
REQ-019 After writing w[NW-1], the FSM SHALL go to DONE: AES_key_busy=0, AES_key_ready=1; start-to-ready latency SHALL be NW-NK+1 cycles (41/47/53).
REQ-020 AES_key_en during EXPAND SHALL be ignored; the running expansion completes unaltered.
REQ-021 A read with AES_rk_rd_en=1 in DONE and addr<=NR SHALL, on the next cycle, drive AES_rk_out with the round-addr key and pulse AES_rk_out_valid for one cycle.
REQ-022 A read with AES_rk_rd_en=1 and addr>NR, or in a state other than DONE, SHALL pulse AES_rk_err next cycle; AES_rk_out_valid stays 0 and AES_rk_out holds.
REQ-023 Back-to-back reads SHALL be supported, one per cycle, in DONE.
REQ-024 AES_key_en and AES_rk_rd_en in the same DONE cycle SHALL be handled as follows: the read is served from the old schedule and the restart proceeds.

Reset
REQ-025 On AES_rst=1 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 (AES_rk_out=128'h0); reset SHALL dominate AES_key_en.
REQ-026 Reset mid-EXPAND SHALL abort expansion; word storage need not be cleared, and AES_key_ready SHALL stay 0 until a new full expansion completes.

Configuration
REQ-027 Macro AES_KEY_DECRYPT_ORDER_EN, when defined, SHALL add input AES_rk_rd_rev (1 bit); when it is high, the served round is NR-addr, for equivalent decryption ordering, and the addr>NR range check still applies to the raw addr.
REQ-028 Without AES_KEY_DECRYPT_ORDER_EN, the port SHALL be absent and reads SHALL always return round addr.

Verification
REQ-029 KEY_BITS=128, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, pulse AES_key_en -> ready after 41 cycles; read addr 10 -> d014f9a8_c9ee2589_e13f0cc8_b6630ca6, valid one cycle.
REQ-030 KEY_BITS=192, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> ready after 47 cycles; addr 12 -> e98ba06f_448c773c_8ecc7204_01002202.
REQ-031 KEY_BITS=256, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 -> ready after 53 cycles; addr 14 -> fe4890d1_e6188d0b_046df344_706c631e; addr 0 -> 603deb10_15ca71be_2b73aef0_857d7781.
REQ-032 KEY_BITS=128, read addr 11 in DONE, and a read during EXPAND -> AES_rk_err pulses, AES_rk_out_valid=0, AES_rk_out unchanged.
REQ-033 AES_rst asserted 20 cycles into EXPAND -> all outputs 0 next cycle, ready stays 0; a restart with the 128-bit key then gives correct round 10 after 41 cycles.
REQ-034 With AES_KEY_DECRYPT_ORDER_EN, KEY_BITS=128: rev=1, addr 0 -> d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
